// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped instruction cache, 8 x 16-byte blocks, miss fill over read/busywait handshake
// Optional hit/miss counters behind ICACHE_STATS_EN.
module icache_direct #(
   parameter int INDEX_BITS = 3,
   parameter int TAG_BITS   = 3
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic [31:0]                     PC,
   output logic [31:0]                     INSTRUCTION,
   output logic                            BUSYWAIT,
   output logic                            mem_read,
   output logic [TAG_BITS+INDEX_BITS-1:0]  mem_address,
   input  logic [127:0]                    mem_readdata,
`ifdef ICACHE_STATS_EN
   output logic [15:0]                     hit_count,
   output logic [15:0]                     miss_count,
`endif
   input  logic                            mem_busywait
);

   localparam int NBLK = 1 << INDEX_BITS;
   localparam int BA_W = TAG_BITS + INDEX_BITS;

   typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

   state_t                 state_q, state_d;
   logic [BA_W-1:0]        addr_q, addr_d;
   logic [127:0]           fill_q, fill_d;
   logic [NBLK-1:0]        valid_q, valid_d;
   logic [TAG_BITS-1:0]    tag_q  [NBLK];
   logic [127:0]           data_q [NBLK];
   logic                   fill_we;

   logic [TAG_BITS-1:0]    pc_tag;
   logic [INDEX_BITS-1:0]  pc_index;
   logic [1:0]             pc_offset;
   logic [INDEX_BITS-1:0]  fill_index;
   logic [127:0]           line;
   logic                   hit;
   logic                   unused_pc;

   assign pc_tag     = PC[4+INDEX_BITS +: TAG_BITS];
   assign pc_index   = PC[4 +: INDEX_BITS];
   assign pc_offset  = PC[3:2];
   assign fill_index = addr_q[INDEX_BITS-1:0];
   assign line       = data_q[pc_index];
   assign hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
   assign unused_pc  = &{1'b0, PC[31:4+INDEX_BITS+TAG_BITS], PC[1:0]};

`ifdef ICACHE_STATS_EN
   logic [15:0] hit_count_q, hit_count_d;
   logic [15:0] miss_count_q, miss_count_d;

   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (state_q == IDLE) begin
         if (hit) hit_count_d  = hit_count_q + 16'd1;
         else     miss_count_d = miss_count_q + 16'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= IDLE;
         addr_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
      end
   end

   // Tags, data and the fill buffer carry no reset; valid alone qualifies them.
   always_ff @(posedge CLK) begin
      fill_q <= fill_d;
      if (RESET && fill_we) begin
         tag_q[fill_index]  <= addr_q[BA_W-1:INDEX_BITS];
         data_q[fill_index] <= fill_q;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      fill_d  = fill_q;
      valid_d = valid_q;
      fill_we = 1'b0;
      case (state_q)
         IDLE: begin
            if (!hit) begin
               addr_d  = {pc_tag, pc_index};
               state_d = MEM_READ;
            end
         end
         MEM_READ: begin
            if (!mem_busywait) begin
               fill_d  = mem_readdata;
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            fill_we             = 1'b1;
            valid_d[fill_index] = 1'b1;
            state_d             = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      INSTRUCTION = 32'h0;
      BUSYWAIT    = 1'b0;
      mem_read    = 1'b0;
      mem_address = '0;
      if (RESET) begin
         case (state_q)
            IDLE: begin
               if (hit) INSTRUCTION = line[{pc_offset, 5'b0} +: 32];
               else     BUSYWAIT    = 1'b1;
            end
            MEM_READ: begin
               BUSYWAIT    = 1'b1;
               mem_read    = 1'b1;
               mem_address = addr_q;
            end
            UPDATE:  BUSYWAIT = 1'b1;
            default: BUSYWAIT = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - randomized self-checking bench for icache_direct against a transaction-level model
// Define ICACHE_STATS_EN to also check the hit/miss counters.
module tb_icache_direct;

   logic         CLK = 1'b0;
   logic         RESET = 1'b0;
   logic [31:0]  PC = '0;
   logic [31:0]  INSTRUCTION;
   logic         BUSYWAIT;
   logic         mem_read;
   logic [5:0]   mem_address;
   logic [127:0] mem_readdata = '0;
   logic         mem_busywait = 1'b0;
`ifdef ICACHE_STATS_EN
   logic [15:0]  hit_count;
   logic [15:0]  miss_count;
`endif

   icache_direct dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .PC           (PC),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
`ifdef ICACHE_STATS_EN
      .hit_count    (hit_count),
      .miss_count   (miss_count),
`endif
      .mem_busywait (mem_busywait)
   );

   always #5 CLK = ~CLK;

   int           n_checks = 0;
   int           n_pass   = 0;
   int           mem_wait = 1;
   int           mr_cnt   = 0;
   int           m_hits   = 0;
   int           m_miss   = 0;
   logic [127:0] mem   [64];
   bit           mvalid [8];
   logic [2:0]   mtag   [8];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Memory holds mem_busywait high for the first mem_wait-1 cycles of each read burst.
   task automatic cycle();
      @(posedge CLK);
      #1;
      if (mem_read) begin
         mem_busywait = (mr_cnt < mem_wait - 1);
         mem_readdata = mem[mem_address];
         mr_cnt++;
      end else begin
         mr_cnt       = 0;
         mem_busywait = 1'b0;
      end
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      cycle();
      check("rst_busywait", 128'(BUSYWAIT), 128'(0));
      check("rst_mem_read", 128'(mem_read), 128'(0));
      check("rst_mem_address", 128'(mem_address), 128'(0));
      check("rst_instruction", 128'(INSTRUCTION), 128'(0));
`ifdef ICACHE_STATS_EN
      check("rst_hit_count", 128'(hit_count), 128'(0));
      check("rst_miss_count", 128'(miss_count), 128'(0));
`endif
      for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
      m_hits = 0;
      m_miss = 0;
      RESET  = 1'b1;
   endtask

   // One CPU fetch: hold PC until the stall ends, compare stall length, memory traffic and the word.
   task automatic fetch(input logic [31:0] pc);
      logic [5:0]   blk;
      int           idx;
      bit           hit;
      int           stall;
      int           mr;
      int           bad;
      logic [127:0] blk_data;
      logic [31:0]  exp_i;
      blk      = pc[9:4];
      idx      = int'(pc[6:4]);
      hit      = mvalid[idx] && (mtag[idx] == pc[9:7]);
      blk_data = mem[blk];
      exp_i    = blk_data[32*int'(pc[3:2]) +: 32];
      stall    = 0;
      mr       = 0;
      bad      = 0;
      PC       = pc;
      #1;
      while (BUSYWAIT && stall < 200) begin
         stall++;
         cycle();
         if (mem_read) begin
            mr++;
            if (mem_address !== blk) bad++;
         end
      end
      check("stall_cycles", 128'(stall), 128'(hit ? 0 : mem_wait + 2));
      check("mem_read_cycles", 128'(mr), 128'(hit ? 0 : mem_wait));
      check("mem_address", 128'(bad), 128'(0));
      check("instruction", 128'(INSTRUCTION), 128'(exp_i));
      check("mem_read_idle", 128'(mem_read), 128'(0));
      if (hit) begin
         m_hits++;
         cycle();
      end else begin
         m_miss++;
         mvalid[idx] = 1'b1;
         mtag[idx]   = pc[9:7];
      end
   endtask

   initial begin
      logic [31:0] pc;
      for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
      mem[0] = {32'h44, 32'h33, 32'h22, 32'h11};
      PC = 32'h80;
      do_reset();

      mem_wait = 5;
      fetch(32'h0);
      fetch(32'h4);
      fetch(32'h8);
      fetch(32'hC);
`ifdef ICACHE_STATS_EN
      check("stats_hits", 128'(hit_count), 128'(3));
      check("stats_misses", 128'(miss_count), 128'(1));
`endif

      fetch(32'h080);
      fetch(32'h0);

      mem_wait = 1;
      fetch(32'h10);

      mem_wait = 4;
      PC = 32'h1A4;
      #1;
      cycle();
      cycle();
      check("midfill_mem_read", 128'(mem_read), 128'(1));
      RESET = 1'b0;
      cycle();
      check("abort_mem_read", 128'(mem_read), 128'(0));
      RESET = 1'b1;
      #1;
      check("abort_idle_mem_read", 128'(mem_read), 128'(0));
      check("abort_miss_again", 128'(BUSYWAIT), 128'(1));
      for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
      m_hits = 0;
      m_miss = 0;
      fetch(32'h1A4);

      for (int n = 0; n < 60; n++) begin
         mem_wait = $urandom_range(1, 4);
         pc       = $urandom;
         pc[9:7]  = 3'($urandom_range(0, 1));
         pc[6:4]  = 3'($urandom_range(0, 3));
         fetch(pc);
      end
`ifdef ICACHE_STATS_EN
      check("final_hits", 128'(hit_count), 128'(m_hits));
      check("final_misses", 128'(miss_count), 128'(m_miss));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
